// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM states, PC-mux selects, instruction types
// and the reserved halt encoding.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        ITYPE_R = 2'b00,
        ITYPE_M = 2'b01,
        ITYPE_B = 2'b10,
        ITYPE_S = 2'b11
    } instr_type_t;

    typedef enum logic [1:0] {
        PC_HOLD      = 2'b00,
        PC_LOAD_ZERO = 2'b01,
        PC_BRANCH    = 2'b10,
        PC_INC       = 2'b11
    } pc_op_t;

    // M-type with subop 3'b111; the decoder never issues this encoding.
    localparam logic [8:0] HALT_INSTR = 9'h0FF;

endpackage

// File: rtl/program_counter.sv
// Program counter register with its hold / load-zero / branch / increment mux.
module program_counter
    import fetch_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  pc_op_t          i_op,
    input  logic [PC_W-1:0] i_branch_target,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_pc_next = r_pc;
        case (i_op)
            PC_HOLD:      w_pc_next = r_pc;
            PC_LOAD_ZERO: w_pc_next = '0;
            PC_BRANCH:    w_pc_next = i_branch_target;
            PC_INC:       w_pc_next = r_pc + PC_W'(1);
            default:      w_pc_next = r_pc;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: IDLE/RUN/HALTED sequencer, retired-instruction counter and
// presentation of the ROM word to the decoder.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stall,
    input  logic [INSTR_W-1:0] instr_data,
    input  logic               branch_en,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    instr_addr,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               done,
    output logic [CNT_W-1:0]   retired
);

    state_t           r_state;
    logic             r_done;
    logic [CNT_W-1:0] r_retired;

    logic             w_running;
    logic             w_is_halt;
    pc_op_t           w_pc_op;
    logic [PC_W-1:0]  w_pc;

    assign w_running = (r_state == ST_RUN);
    assign w_is_halt = (instr_data == INSTR_W'(HALT_INSTR));

    // Halt outranks a taken branch; stall outranks both.
    always_comb begin
        w_pc_op = PC_HOLD;
        case (r_state)
            ST_IDLE, ST_HALTED: begin
                if (start) w_pc_op = PC_LOAD_ZERO;
            end
            ST_RUN: begin
                if (!stall) begin
                    if (w_is_halt)      w_pc_op = PC_HOLD;
                    else if (branch_en) w_pc_op = PC_BRANCH;
                    else                w_pc_op = PC_INC;
                end
            end
            default: w_pc_op = PC_HOLD;
        endcase
    end

    program_counter #(
        .PC_W(PC_W)
    ) u_pc (
        .clk            (clk),
        .reset          (reset),
        .i_op           (w_pc_op),
        .i_branch_target(branch_target),
        .o_pc           (w_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_retired <= '0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        r_state   <= ST_RUN;
                        r_retired <= '0;
                        r_done    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        // Counter saturates rather than wrapping.
                        if (r_retired != '1) r_retired <= r_retired + CNT_W'(1);
                        if (w_is_halt) begin
                            r_state <= ST_HALTED;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign instr_addr  = w_pc;
    assign pc          = w_pc;
    assign instr       = w_running ? instr_data : '0;
    assign instr_valid = w_running;
    assign done        = r_done;
    assign retired     = r_retired;

endmodule
